// File: rtl/debounce_sync_if.sv
// Signal bundle between a raw-level source and the debounce_sync conditioner.
// Handshake: none. din is a free-running asynchronous level. All outputs are registered levels or 1-cycle strobes in the clk domain.
interface debounce_sync_if;
  logic       din;
  logic       dout;
  logic       dout_b;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [1:0] dbg_state;

  modport master (
    output din,
    input  dout, dout_b, rise, fall, busy, dbg_state
  );

  modport slave (
    input  din,
    output dout, dout_b, rise, fall, busy, dbg_state
  );
endinterface

// File: rtl/debounce_sync.sv
// Synchronises one asynchronous input and accepts a new level only after it has
// been stable for STABLE_CNT consecutive clocks. Also emits rise/fall strobes and a busy flag.
module debounce_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int STABLE_CNT  = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  debounce_sync_if.slave  bus
);

  localparam logic [1:0] S_LOW    = 2'd0;
  localparam logic [1:0] S_CHK_HI = 2'd1;
  localparam logic [1:0] S_HIGH   = 2'd2;
  localparam logic [1:0] S_CHK_LO = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("debounce_sync: SYNC_STAGES must be 2..4");
    end
    if (STABLE_CNT < 2) begin : g_bad_cnt_lo
      $error("debounce_sync: STABLE_CNT must be at least 2");
    end
    if (64'(STABLE_CNT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_cnt_hi
      $error("debounce_sync: STABLE_CNT does not fit in CNT_W bits");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [1:0]             state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   dout_q, dout_b_q, rise_q, fall_q, busy_q;
  logic                   rise_nxt, fall_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.din};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A reversal of s while checking returns to the settled state and discards the count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      S_LOW: begin
        if (s) begin
          state_nxt = S_CHK_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      S_CHK_HI: begin
        if (!s) begin
          state_nxt = S_LOW;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HIGH;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!s) begin
          state_nxt = S_CHK_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      S_CHK_LO: begin
        if (s) begin
          state_nxt = S_HIGH;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LOW;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_LOW;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_LOW;
      cnt      <= '0;
      dout_q   <= 1'b0;
      dout_b_q <= 1'b1;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rise_q   <= rise_nxt;
      fall_q   <= fall_nxt;
      busy_q   <= (state_nxt == S_CHK_HI) || (state_nxt == S_CHK_LO);
      if (rise_nxt) begin
        dout_q   <= 1'b1;
        dout_b_q <= 1'b0;
      end else if (fall_nxt) begin
        dout_q   <= 1'b0;
        dout_b_q <= 1'b1;
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_b    = dout_b_q;
  assign bus.rise      = rise_q;
  assign bus.fall      = fall_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync (SYNC_STAGES=2, STABLE_CNT=4) against a
// run-length reference model of the debounce rules.
module tb_debounce_sync;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  debounce_sync_if bus ();

  debounce_sync #(.SYNC_STAGES(SYNC), .CNT_W(16), .STABLE_CNT(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: din samples delayed SYNC edges, then a run length of samples
  // that disagree with the accepted level; STABLE disagreeing samples flip it.
  logic mq[$];
  logic m_dout, m_rise, m_fall;
  int   m_run;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);
    m_dout = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_run  = 0;
  endtask

  task automatic tick(input logic d);
    logic s;
    bus.din = d;
    @(posedge clk);
    if (rst_n) begin
      s = mq.pop_front();
      mq.push_back(d);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_dout) begin
        m_run++;
        if (m_run == STABLE) begin
          m_dout = s;
          m_rise = s;
          m_fall = !s;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      model_reset();
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b1;
    bus.din = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({bus.dout, bus.dout_b, bus.rise, bus.fall, bus.busy} !== 5'b01000) begin
      n_bad++;
      $display("FAIL reset: {dout,dout_b,rise,fall,busy}=%b want 01000", {bus.dout, bus.dout_b, bus.rise, bus.fall, bus.busy});
    end
    tick(1'b0);
    tick(1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0);
    n_cmp++;
    if ({bus.dout, bus.dout_b, bus.busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL reset_idle: {dout,dout_b,busy}=%b want 010", {bus.dout, bus.dout_b, bus.busy});
    end
  endtask

  task automatic test_clean_rise();
    for (int e = 1; e <= 8; e++) begin
      tick(1'b1);
      n_cmp++;
      if ({bus.dout, bus.dout_b, bus.rise, bus.fall, bus.busy} !== {m_dout, !m_dout, m_rise, m_fall, m_run > 0}) begin
        n_bad++;
        $display("FAIL clean_rise_model e%0d: got %b want %b", e, {bus.dout, bus.dout_b, bus.rise, bus.fall, bus.busy}, {m_dout, !m_dout, m_rise, m_fall, m_run > 0});
      end
      n_cmp++;
      if (bus.busy !== (e >= 3 && e <= 5)) begin
        n_bad++;
        $display("FAIL clean_rise_busy e%0d: got %b want %b", e, bus.busy, (e >= 3 && e <= 5));
      end
      n_cmp++;
      if (bus.rise !== (e == 6) || bus.dout !== (e >= 6)) begin
        n_bad++;
        $display("FAIL clean_rise_edge e%0d: rise=%b dout=%b want rise=%b dout=%b", e, bus.rise, bus.dout, (e == 6), (e >= 6));
      end
    end
  endtask

  task automatic test_clean_fall();
    for (int e = 1; e <= 8; e++) begin
      tick(1'b0);
      n_cmp++;
      if ({bus.dout, bus.dout_b, bus.rise, bus.fall, bus.busy} !== {m_dout, !m_dout, m_rise, m_fall, m_run > 0}) begin
        n_bad++;
        $display("FAIL clean_fall_model e%0d: got %b want %b", e, {bus.dout, bus.dout_b, bus.rise, bus.fall, bus.busy}, {m_dout, !m_dout, m_rise, m_fall, m_run > 0});
      end
      n_cmp++;
      if (bus.fall !== (e == 6) || bus.dout !== (e < 6) || bus.dout_b !== (e >= 6)) begin
        n_bad++;
        $display("FAIL clean_fall_edge e%0d: fall=%b dout=%b dout_b=%b", e, bus.fall, bus.dout, bus.dout_b);
      end
    end
  endtask

  task automatic test_glitch();
    int rises;
    rises = 0;
    for (int e = 1; e <= 12; e++) begin
      tick(e <= 3);
      if (bus.rise) rises++;
      n_cmp++;
      if (bus.dout !== 1'b0) begin
        n_bad++;
        $display("FAIL glitch_dout e%0d: got %b want 0", e, bus.dout);
      end
    end
    n_cmp++;
    if (rises != 0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_end: rises=%0d busy=%b want 0 0", rises, bus.busy);
    end
  endtask

  task automatic test_bounce();
    logic pat[5];
    int   rises, rise_edge;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rises = 0;
    rise_edge = 0;
    for (int e = 1; e <= 16; e++) begin
      tick(e <= 5 ? pat[e-1] : 1'b1);
      if (bus.rise) begin
        rises++;
        rise_edge = e;
      end
      n_cmp++;
      if ({bus.dout, bus.rise, bus.busy} !== {m_dout, m_rise, m_run > 0}) begin
        n_bad++;
        $display("FAIL bounce_model e%0d: got %b want %b", e, {bus.dout, bus.rise, bus.busy}, {m_dout, m_rise, m_run > 0});
      end
    end
    n_cmp++;
    if (rises != 1 || rise_edge != 10) begin
      n_bad++;
      $display("FAIL bounce_rise: count=%0d edge=%0d want 1 at edge 10", rises, rise_edge);
    end
  endtask

  task automatic test_reset_mid_qualify();
    int rise_edge;
    for (int e = 1; e <= 3; e++) tick(1'b0);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre_busy: got %b want 1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({bus.busy, bus.dout, bus.dout_b} !== 3'b001) begin
      n_bad++;
      $display("FAIL mid_reset: {busy,dout,dout_b}=%b want 001", {bus.busy, bus.dout, bus.dout_b});
    end
    bus.din = 1'b1;
    #2 rst_n = 1'b1;
    rise_edge = 0;
    for (int e = 1; e <= 9; e++) begin
      tick(1'b1);
      if (bus.rise && rise_edge == 0) rise_edge = e;
    end
    n_cmp++;
    if (rise_edge != 6) begin
      n_bad++;
      $display("FAIL mid_release_rise: edge=%0d want 6", rise_edge);
    end
  endtask

  task automatic test_random();
    logic d;
    int   run;
    d = 1'b0;
    run = 0;
    for (int i = 0; i < 600; i++) begin
      if (run == 0) begin
        d   = ~d;
        run = $urandom_range(1, 8);
      end
      run--;
      tick(d);
      n_cmp++;
      if ({bus.dout, bus.dout_b, bus.rise, bus.fall, bus.busy} !== {m_dout, !m_dout, m_rise, m_fall, m_run > 0}) begin
        n_bad++;
        $display("FAIL random_model i%0d: got %b want %b", i, {bus.dout, bus.dout_b, bus.rise, bus.fall, bus.busy}, {m_dout, !m_dout, m_rise, m_fall, m_run > 0});
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    bus.din = 1'b0;
    rst_n   = 1'b1;
    model_reset();
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_glitch();
    test_bounce();
    test_reset_mid_qualify();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
